ex_div_ctrl: RTL
================

Name: ex_div_ctrl

Overview:
- Iterative shift-subtract divider with its sequencing FSM. It serves the EX stage's div/mod ALU ops, which stall EX ready-go until a result is available.
- Accepts one operand pair per transaction through a valid/ready handshake. Runs one quotient bit per cycle, fixes signs, then holds the result until EX consumes it.
- A pipeline flush cancels the transaction in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- div_valid  in  1  EX holds a valid div/mod op with operands stable.
- div_ready  out  1  controller can accept (state IDLE).
- div_signed  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
- div_src1  in  WIDTH  dividend.
- div_src2  in  WIDTH  divisor.
- flush  in  1  cancel any transaction (exception/branch kill of EX).
- res_valid  out  1  quotient/remainder valid and held.
- res_ack  in  1  EX moves to ME this cycle (EX_Valid && ME_Allow_in).
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; counter=0; res_valid=0; quotient=0; remainder=0.
  - div_ready=1 and busy=0 once resetn deasserts.
- States are IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - div_ready=1.
  - On div_valid && !flush, latch src1, src2 and div_signed, then go to PREP (accept cycle T).
- PREP (T+1):
  - Compute |src1| and |src2|; magnitude applies only if div_signed, else raw.
  - Record sign_q = s1^s2 and sign_r = s1, where s1/s2 are the operand MSBs when signed and 0 otherwise.
  - Clear the partial remainder; load counter=WIDTH.
  - If divisor==0, go to FIX; else go to CALC.
- CALC (T+2 .. T+WIDTH+1):
  - Each cycle, shift {rem,dvd} left by 1.
  - If rem_shift >= divisor, set rem=rem_shift-divisor and shift 1 into the quotient; else shift 0 in.
  - Decrement the counter; when counter reaches 1, go to FIX.
- FIX (T+WIDTH+2):
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r. Go to DONE.
- Divide by zero: quotient = all ones, remainder = original src1 (no sign fix).
- Signed overflow 0x80000000 / -1: quotient = 0x80000000, remainder = 0. This falls out of the unsigned magnitude path; no special case.
- DONE:
  - res_valid=1 first in cycle T+WIDTH+3 (T+35 at WIDTH=32); T+3 for divide by zero.
  - quotient and remainder are held stable while waiting.
  - On res_ack, go to IDLE with res_valid=0 the next cycle.
  - A new op may be accepted no earlier than the cycle after ack.
- flush in any state:
  - Next state is IDLE and res_valid=0.
  - quotient/remainder keep stale values; do not consume them.
  - flush with div_valid in the same cycle: flush wins, no accept.
  - flush and res_ack together in DONE: go to IDLE, same result.
- res_ack outside DONE is ignored.
- Operand changes after accept have no effect.
- Arithmetic: the remainder register is WIDTH+1 bits so the compare/subtract never overflows. Negation is two's complement, modulo 2^WIDTH.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- Defined: in PREP, if |src1| < |src2| (and divisor != 0), skip CALC and go to FIX with q=0, r=|src1|. res_valid is then first asserted in cycle T+3.
- Undefined: every nonzero-divisor op takes the full T+WIDTH+3 latency.
- Results are identical either way.

Test Plan:
- Unsigned 100/7: div_valid at T, div_signed=0 -> res_valid first at T+35; quotient=14, remainder=2; held until res_ack, then res_valid=0 and div_ready=1 the next cycle.
- Signed -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7/-2 -> -3, 1.
- Divide by zero 0x1234/0 (signed and unsigned) -> res_valid at T+3; quotient=0xFFFFFFFF, remainder=0x1234.
- Overflow 0x80000000 / 0xFFFFFFFF, signed -> quotient=0x80000000, remainder=0, at T+35.
- flush at T+10 mid-CALC -> IDLE at T+11, no res_valid. A new 9/3 accepted at T+11 -> quotient=3, remainder=0 at T+46.
- resetn pulsed low mid-CALC -> immediate IDLE with res_valid=0. Under DIV_EARLY_TERM_EN, 3/10 -> res_valid at T+3, quotient=0, remainder=3.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl - iterative shift-subtract divider and its sequencing FSM for
// the EX-stage div/mod ops. It produces one quotient bit per cycle, applies
// the sign fix, then holds the result until EX consumes it.
//
// Optional feature macro: DIV_EARLY_TERM_EN. When it is defined, an op whose
// |dividend| < |divisor| skips CALC. The results are the same either way.
//
// Ports:
//   clk, resetn               core clock and async active-low reset
//   div_valid / div_ready     operand handshake (ready only in IDLE)
//   div_signed                1 = signed op, 0 = unsigned op
//   div_src1 / div_src2       dividend / divisor
//   flush                     cancels any transaction in flight
//   res_valid / res_ack       result held valid until EX moves to ME
//   quotient / remainder      registered results
//   busy                      controller is not in IDLE
//
// state | meaning
// IDLE  | waiting for an op; div_ready=1
// PREP  | take magnitudes, record signs, load counter
// CALC  | one quotient bit per cycle
// FIX   | apply sign fix or the divide-by-zero result
// DONE  | result held until res_ack
module ex_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] src1_q, src2_q;
  logic             signed_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out at the top, quotient bits enter at the bottom
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;   // one spare bit so the compare/subtract cannot overflow
  logic             sign_q_q, sign_r_q, dz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             res_valid_q;

  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             ge;

  always_comb begin
    s1        = signed_q & src1_q[WIDTH-1];
    s2        = signed_q & src2_q[WIDTH-1];
    mag1      = s1 ? -src1_q : src1_q;
    mag2      = s2 ? -src2_q : src2_q;
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    ge        = rem_shift >= {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      signed_q    <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      res_valid_q <= 1'b0;
    end else if (flush) begin
      // Results stay stale on purpose; res_valid low marks them unusable.
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid) begin
            src1_q   <= div_src1;
            src2_q   <= div_src2;
            signed_q <= div_signed;
            state_q  <= PREP;
          end
        end
        PREP: begin
          dvd_q    <= mag1;
          dvs_q    <= mag2;
          rem_q    <= '0;
          cnt_q    <= CNT_W'(WIDTH);
          sign_q_q <= s1 ^ s2;
          sign_r_q <= s1;
          dz_q     <= (src2_q == '0);
          if (src2_q == '0) begin
            state_q <= FIX;
`ifdef DIV_EARLY_TERM_EN
          end else if (mag1 < mag2) begin
            dvd_q   <= '0;
            rem_q   <= {1'b0, mag1};
            state_q <= FIX;
`endif
          end else begin
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= ge ? rem_sub : rem_shift;
          dvd_q <= {dvd_q[WIDTH-2:0], ge};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          if (dz_q) begin
            quotient_q  <= '1;
            remainder_q <= src1_q;
          end else begin
            quotient_q  <= sign_q_q ? -dvd_q : dvd_q;
            remainder_q <= sign_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (res_ack) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign div_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
